// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the playfield draw scheduler.
// The BORDER state exists only when DRAW_SCHED_BORDER_EN is defined.
package draw_scheduler_pkg;

`ifdef DRAW_SCHED_BORDER_EN
  typedef enum logic [2:0] {S_IDLE, S_BORDER, S_WALL, S_DUDE, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WALL, S_DUDE, S_FIN} state_t;
`endif

  localparam int FIELD_W = 120;
  localparam int FIELD_H = 100;
  localparam int DUDE_W  = 4;
  localparam int DUDE_H  = 6;
  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

  localparam logic [2:0] WALL_ON  = 3'b111;
  localparam logic [2:0] WALL_OFF = 3'b000;
  localparam logic [2:0] DUDE     = 3'b100;
  localparam logic [2:0] BORDER   = 3'b010;

  function automatic logic on_screen(input logic [8:0] px, input logic [8:0] py);
    return (px <= 9'(SCREEN_X_MAX)) && (py <= 9'(SCREEN_Y_MAX));
  endfunction

endpackage

// File: rtl/draw_scheduler_rect.sv
// rect_scan: column-major rectangle walker (inner counter wraps into outer),
// returning to 0,0 after the last point so consecutive passes need no clear.
module rect_scan #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] outer_max,
  input  logic [W-1:0] inner_max,
  output logic [W-1:0] outer,
  output logic [W-1:0] inner,
  output logic         last
);

  assign last = (outer == outer_max) && (inner == inner_max);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      outer <= '0;
      inner <= '0;
    end else if (en) begin
      if (inner == inner_max) begin
        inner <= '0;
        outer <= (outer == outer_max) ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame draw sequencer: [border], wall map, dude block, then a done pulse.
// Optional border pass enabled by DRAW_SCHED_BORDER_EN.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int FIELD_X0 = 20,
  parameter int FIELD_Y0 = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [6:0] hdude,
  input  logic [7:0] vdude,
  output logic [6:0] rd_col,
  output logic [6:0] rd_row,
  input  logic       wall_bit,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output state_t     state_dbg
);

`ifdef DRAW_SCHED_BORDER_EN
  localparam state_t FIRST = S_BORDER;
  logic [1:0] seg;
`else
  localparam state_t FIRST = S_WALL;
`endif

  state_t     state, state_nxt;
  logic       pending;
  logic [6:0] hd_q;
  logic [7:0] vd_q;
  logic       begin_frame;

  logic       scan_en, scan_last;
  logic [6:0] outer_max, inner_max, outer, inner;

  // emitted pixel (e_*) and its registered copy driving the outputs (p_*)
  logic       e_valid, e_wall, e_last;
  logic [8:0] e_x, e_y;
  logic [2:0] e_colour;
  logic       p_valid, p_wall, p_last;
  logic [7:0] p_x;
  logic [6:0] p_y;
  logic [2:0] p_colour;

  rect_scan #(.W(7)) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .en        (scan_en),
    .outer_max (outer_max),
    .inner_max (inner_max),
    .outer     (outer),
    .inner     (inner),
    .last      (scan_last)
  );

  assign begin_frame = ((state == S_IDLE) && start) ||
                       ((state == S_FIN) && (pending || start));

  always_comb begin
    state_nxt = state;
    scan_en   = 1'b0;
    outer_max = '0;
    inner_max = '0;
    e_valid   = 1'b0;
    e_wall    = 1'b0;
    e_last    = 1'b0;
    e_x       = '0;
    e_y       = '0;
    e_colour  = '0;
    case (state)
      S_IDLE: if (start) state_nxt = FIRST;
`ifdef DRAW_SCHED_BORDER_EN
      S_BORDER: begin
        scan_en  = 1'b1;
        e_valid  = 1'b1;
        e_colour = BORDER;
        if (seg < 2'd2) begin
          outer_max = 7'(FIELD_W + 1);
          e_x = 9'(FIELD_X0 - 1) + 9'(outer);
          e_y = (seg == 2'd0) ? 9'(FIELD_Y0 - 1) : 9'(FIELD_Y0 + FIELD_H);
        end else begin
          inner_max = 7'(FIELD_H - 1);
          e_x = (seg == 2'd2) ? 9'(FIELD_X0 - 1) : 9'(FIELD_X0 + FIELD_W);
          e_y = 9'(FIELD_Y0) + 9'(inner);
        end
        if (scan_last && seg == 2'd3) state_nxt = S_WALL;
      end
`endif
      S_WALL: begin
        scan_en   = 1'b1;
        outer_max = 7'(FIELD_W - 1);
        inner_max = 7'(FIELD_H - 1);
        e_valid   = 1'b1;
        e_wall    = 1'b1;
        e_x       = 9'(FIELD_X0) + 9'(outer);
        e_y       = 9'(FIELD_Y0) + 9'(inner);
        if (scan_last) state_nxt = S_DUDE;
      end
      S_DUDE: begin
        // one extra cycle after the last pixel lets it reach the outputs before FIN
        scan_en   = !p_last;
        outer_max = 7'(DUDE_W - 1);
        inner_max = 7'(DUDE_H - 1);
        e_colour  = DUDE;
        e_x       = 9'(FIELD_X0) + 9'(hd_q) + 9'(outer);
        e_y       = 9'(FIELD_Y0) + 9'(vd_q) + 9'(inner);
        e_valid   = !p_last && on_screen(e_x, e_y);
        e_last    = !p_last && scan_last;
        if (p_last) state_nxt = S_FIN;
      end
      S_FIN: state_nxt = (pending || start) ? FIRST : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      hd_q    <= '0;
      vd_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FIN)
        pending <= 1'b0;
      else if (state != S_IDLE && start)
        pending <= 1'b1;
      if (begin_frame) begin
        hd_q <= hdude;
        vd_q <= vdude;
      end
    end
  end

`ifdef DRAW_SCHED_BORDER_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      seg <= '0;
    else if (state == S_BORDER && scan_last)
      seg <= seg + 2'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_valid  <= 1'b0;
      p_wall   <= 1'b0;
      p_last   <= 1'b0;
      p_x      <= '0;
      p_y      <= '0;
      p_colour <= '0;
    end else begin
      p_valid  <= e_valid;
      p_wall   <= e_wall;
      p_last   <= e_last;
      p_x      <= e_x[7:0];
      p_y      <= e_y[6:0];
      p_colour <= e_colour;
    end
  end

  // wall_bit arrives in the same cycle as the registered pixel it colours
  assign colour    = p_wall ? (wall_bit ? WALL_ON : WALL_OFF) : p_colour;
  assign plot      = p_valid;
  assign x         = p_x;
  assign y         = p_y;
  assign rd_col    = (state == S_WALL) ? outer : 7'd0;
  assign rd_row    = (state == S_WALL) ? inner : 7'd0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: per-cycle expected stream built from the frame rules
// (pixel lists and latencies), a registered wall-map model, and a final report.
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;

  localparam int X0 = 20;
  localparam int Y0 = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [6:0] hdude = '0;
  logic [7:0] vdude = '0;
  logic [6:0] rd_col, rd_row;
  logic       wall_bit = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  state_t     state_dbg;

  int checks = 0;
  int failures = 0;
  int exp_plots, exp_white, obs_plots, obs_white;
  bit wall_map [0:11999];
  logic [20:0] exp_q[$];

  draw_scheduler #(.FIELD_X0(X0), .FIELD_Y0(Y0)) dut (
    .clk(clk), .resetn(resetn), .start(start), .hdude(hdude), .vdude(vdude),
    .rd_col(rd_col), .rd_row(rd_row), .wall_bit(wall_bit), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // wall memory: one-cycle registered read
  always @(posedge clk)
    wall_bit <= (rd_col < 7'd120 && rd_row < 7'd100) ?
                wall_map[int'(rd_col) * 100 + int'(rd_row)] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input bit b, input bit d, input bit p, input int px, input int py, input int pc);
    if (p) begin
      exp_q.push_back({b, d, p, 8'(px), 7'(py), 3'(pc)});
      exp_plots++;
      if (pc == 7) exp_white++;
    end else begin
      exp_q.push_back({b, d, p, 18'h0});
    end
  endtask

  task automatic build_frame(input int h, input int v);
    push(1, 0, 0, 0, 0, 0);
`ifdef DRAW_SCHED_BORDER_EN
    for (int i = 0; i < 122; i++) push(1, 0, 1, X0 - 1 + i, Y0 - 1, 2);
    for (int i = 0; i < 122; i++) push(1, 0, 1, X0 - 1 + i, Y0 + 100, 2);
    for (int j = 0; j < 100; j++) push(1, 0, 1, X0 - 1, Y0 + j, 2);
    for (int j = 0; j < 100; j++) push(1, 0, 1, X0 + 120, Y0 + j, 2);
`endif
    for (int c = 0; c < 120; c++)
      for (int r = 0; r < 100; r++)
        push(1, 0, 1, X0 + c, Y0 + r, wall_map[c * 100 + r] ? 7 : 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++) begin
        int xx = X0 + h + i;
        int yy = Y0 + v + j;
        if (xx > 159 || yy > 119) push(1, 0, 0, 0, 0, 0);
        else push(1, 0, 1, xx, yy, 4);
      end
    push(1, 1, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_rd_col"}, rd_col, 0);
    check({tag, "_rd_row"}, rd_row, 0);
    check({tag, "_state"}, state_dbg, S_IDLE);
  endtask

  // Drives a start now (cycle 0); extra starts at cycles extra_a/extra_b;
  // optional reset at cycle rst_at. Checks every following cycle.
  task automatic run_frames(input int h, input int v, input int extra_a,
                            input int extra_b, input int rst_at, input string name);
    logic [20:0] obs;
    int n_frames;
    n_frames = (extra_a > 0 || extra_b > 0) ? 2 : 1;
    exp_plots = 0; exp_white = 0; obs_plots = 0; obs_white = 0;
    for (int f = 0; f < n_frames; f++) build_frame(h, v);
    push(0, 0, 0, 0, 0, 0);
    hdude = 7'(h);
    vdude = 8'(v);
    start = 1'b1;
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      obs = {busy, done, plot, plot ? {x, y, colour} : 18'h0};
      check($sformatf("%s_cyc%0d", name, k), obs, exp_q.pop_front());
      if (plot) begin
        obs_plots++;
        if (colour == 3'b111) obs_white++;
      end
      start = (k == extra_a) || (k == extra_b);
      if (k == rst_at) begin
        resetn = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_reset_values({name, "_midrst"});
        resetn = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_post_rst_busy"}, busy, 0);
        exp_q.delete();
        return;
      end
    end
    check({name, "_plots"}, obs_plots, exp_plots);
    check({name, "_white"}, obs_white, exp_white);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    @(negedge clk);

    // single wall bit at (5,7), dude at origin
    for (int i = 0; i < 12000; i++) wall_map[i] = 1'b0;
    wall_map[5 * 100 + 7] = 1'b1;
    run_frames(0, 0, 0, 0, 0, "single");

    // random map, dude partly off the bottom edge
    for (int i = 0; i < 12000; i++) wall_map[i] = ($urandom_range(0, 3) == 0);
    run_frames($urandom_range(0, 127), 108, 0, 0, 0, "bottom");

    // queued start then a dropped one
    run_frames($urandom_range(0, 127), $urandom_range(0, 255), 500, 600, 0, "pending");

    // reset mid-frame, then a fresh frame
    run_frames($urandom_range(0, 127), $urandom_range(0, 255), 0, 0, 6000, "reset6000");
    run_frames(0, 0, 0, 0, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter FIELD_X0, default 20, meaning screen x of playfield column 0.
REQ-002 SHALL have parameter FIELD_Y0, default 10, meaning screen y of playfield row 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to draw a frame.
REQ-006 SHALL have port hdude, input, 7 bits: dude column, top-left, playfield coordinates.
REQ-007 SHALL have port vdude, input, 8 bits: dude row, top-left, playfield coordinates.
REQ-008 SHALL have port rd_col, output, 7 bits: wall-map read column, range 0..119.
REQ-009 SHALL have port rd_row, output, 7 bits: wall-map read row, range 0..99.
REQ-010 SHALL have port wall_bit, input, 1 bit: wall-map data, valid exactly 1 cycle after rd_col/rd_row.
REQ-011 SHALL have port x, output, 8 bits: plot x coordinate, to vga_adapter.
REQ-012 SHALL have port y, output, 7 bits: plot y coordinate, to vga_adapter.
REQ-013 SHALL have port colour, output, 3 bits: plot colour.
REQ-014 SHALL have port plot, output, 1 bit: pixel write strobe.
REQ-015 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when the last pixel of a frame is plotted.

Function
REQ-017 SHALL implement FSM states IDLE -> [BORDER] -> WALL -> DUDE -> FIN -> IDLE.
REQ-018 IDLE: start=1 SHALL move to the first draw state next cycle and latch hdude/vdude for the whole frame.
REQ-019 WALL: SHALL issue rd_col/rd_row column-major (row 0..99 inner, col 0..119 outer), one address per cycle, 12000 addresses.
REQ-020 WALL plot timing:
- plot SHALL assert 1 cycle after each address.
- x=FIELD_X0+col, y=FIELD_Y0+row of that address.
- colour=3'b111 if wall_bit else 3'b000.
REQ-021 DUDE: SHALL plot a 4-wide x 6-tall block, colour 3'b100, x=FIELD_X0+hdude+i, y=FIELD_Y0+vdude+j; i outer, j inner, 24 cycles.
REQ-022 Dude pixels with computed x>159 or y>119 SHALL have plot=0 for that cycle; the cycle count is unchanged.
REQ-023 FIN: done=1 for exactly one cycle, coincident with no plot; SHALL return to IDLE next cycle.
REQ-024 Latency: first plot 2 cycles after start; done 12000+24+2 cycles after start (without border).
REQ-025 start while busy SHALL set a single pending flag; further starts are dropped.
REQ-026 A set pending flag SHALL cause FIN to go directly to the first draw state and clear the flag.
REQ-027 Address/coordinate arithmetic SHALL be unsigned; counters SHALL wrap only at the stated limits, never by overflow.
REQ-028 plot SHALL be 0 in IDLE and FIN; x/y/colour are don't-care when plot=0.

Reset
REQ-029 resetn=0 at any cycle, including mid-frame, SHALL next cycle force:
- state IDLE, pending=0;
- plot=0, busy=0, done=0;
- x=0, y=0, colour=0;
- rd_col=0, rd_row=0.
REQ-030 A start coincident with resetn=0 SHALL be ignored.

Configuration
REQ-031 Macro DRAW_SCHED_BORDER_EN defined:
- BORDER state precedes WALL.
- Plots colour 3'b010 around the playfield: top row y=FIELD_Y0-1 and bottom row y=FIELD_Y0+100, x=FIELD_X0-1..FIELD_X0+120 (122 each).
- Left/right columns x=FIELD_X0-1 and FIELD_X0+120, y=FIELD_Y0..FIELD_Y0+99 (100 each).
- 444 cycles; all latencies grow by 444.
REQ-032 Macro undefined: no BORDER state or logic; WALL follows IDLE directly.

Structure
REQ-033 Shared package holds:
- state enum;
- FIELD_W=120, FIELD_H=100, DUDE_W=4, DUDE_H=6;
- colour constants WALL_ON, WALL_OFF, DUDE, BORDER.
REQ-034 Sub-module rect_scan (two nested counters, x/y offset, last flag) SHALL be reused by WALL, DUDE and BORDER passes.

Verification
REQ-035 Reset, start pulse, wall model returns 1 only at (col 5, row 7) -> exactly one plot with colour 111 at (25,17); 11999 wall plots with 000; done at cycle 12026.
REQ-036 hdude=0, vdude=0 -> dude plots (20..23, 10..15) with colour 100, 24 strobes.
REQ-037 vdude=108 -> dude y=118,119 plotted; y=120..123 suppressed; done timing unchanged.
REQ-038 Second start at cycle 500, third at cycle 600 -> exactly two frames; second starts at the cycle after the first done; busy held high throughout.
REQ-039 resetn=0 at cycle 6000 -> plot=0, busy=0 next cycle; new start gives first plot (20,10) 2 cycles later.
REQ-040 DRAW_SCHED_BORDER_EN defined -> first plot (19,9) colour 010; 444 border plots; done at cycle 12470.
